// File: rtl/multiword_comparator_seq.sv
// Word-serial unsigned magnitude comparator.
// Operands of 24*WORDS bits are compared one 24-bit word per clock,
// least significant word first. The three running flags go back into the
// cascade inputs of a single 24-bit comparator, so the most significant
// word that differs decides the final result.

// 24-bit cascadable magnitude comparator. A word that differs decides the
// result; equal words pass the cascade inputs through.
module comparator_24 (
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        greatin,
    input  logic        equalin,
    input  logic        lessin,
    output logic        great,
    output logic        equal,
    output logic        less
);
    logic word_eq;

    assign word_eq = (a == b);
    assign great   = (a > b) | (word_eq & greatin);
    assign equal   = word_eq & equalin;
    assign less    = (a < b) | (word_eq & lessin);
endmodule

module multiword_comparator_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [24*WORDS-1:0]   a,
    input  logic [24*WORDS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  great,
    output logic                  equal,
    output logic                  less
);
    // One spare bit, so idx can step past the last word without wrapping.
    localparam int IDX_W = $clog2(WORDS) + 1;
    localparam int SEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic great;
        logic equal;
        logic less;
    } flags_t;

    localparam flags_t FLAGS_CLEAR = '{great: 1'b0, equal: 1'b0, less: 1'b0};
    localparam flags_t FLAGS_START = '{great: 1'b0, equal: 1'b1, less: 1'b0};

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    flags_t                  run_q, run_d;
    flags_t                  res_q, res_d;
    logic [WORDS-1:0][23:0]  a_q, b_q;
    logic                    load;
    logic [SEL_W-1:0]        sel;
    flags_t                  cmp;

    assign sel = idx_q[SEL_W-1:0];

    comparator_24 u_cmp (
        .a       (a_q[sel]),
        .b       (b_q[sel]),
        .greatin (run_q.great),
        .equalin (run_q.equal),
        .lessin  (run_q.less),
        .great   (cmp.great),
        .equal   (cmp.equal),
        .less    (cmp.less)
    );

    // Next-state and datapath control: accept, step one word, hold the result.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        res_d   = res_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    run_d   = FLAGS_START;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                run_d = cmp;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    res_d   = cmp;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and flags, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            run_q   <= FLAGS_CLEAR;
            res_q   <= FLAGS_CLEAR;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            res_q   <= res_d;
        end
    end

    // Operand capture on accept.
    always_ff @(posedge clk) begin
        // NOTE: operand registers are not reset; they are only read after an accept has loaded them.
        if (load) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign great     = res_q.great;
    assign equal     = res_q.equal;
    assign less      = res_q.less;
endmodule

// File: tb/tb_multiword_comparator_seq.sv
// Self-checking bench for multiword_comparator_seq with WORDS=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multiword_comparator_seq;
    localparam int WORDS = 4;
    localparam int W     = 24 * WORDS;
    localparam int TMO   = 50;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic         great;
    logic         equal;
    logic         less;

    int n_checks;
    int n_errors;
    int overlap_cnt;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   exp;   // {great, equal, less}
        string        name;
    } vec_t;

    vec_t vecs[8];

    multiword_comparator_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .great     (great),
        .equal     (equal),
        .less      (less)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_ready and out_valid must never be high together.
    always @(negedge clk) begin
        if (rst_n && in_ready && out_valid) overlap_cnt++;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x > y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    // Present an operand pair at a falling edge and let it be accepted.
    task automatic accept(input logic [W-1:0] xa, input logic [W-1:0] xb, input string name);
        int t;
        t = 0;
        while (!in_ready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        check({name, " ready"}, W'(in_ready), W'(1));
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = {$urandom, $urandom, $urandom};
        b        = {$urandom, $urandom, $urandom};
    endtask

    // Called at the falling edge right after the accept edge.
    task automatic wait_result(input logic [2:0] exp, input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, W'(lat), W'(WORDS));
        check({name, " flags"}, W'({great, equal, less}), W'(exp));
    endtask

    // Hold out_ready low for some cycles, then complete the handshake.
    task automatic release_result(input int stall, input logic [2:0] exp, input string name);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({name, " hold"}, W'({out_valid, in_ready, great, equal, less}), W'({2'b10, exp}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " idle"}, W'({out_valid, in_ready}), W'(2'b01));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] nxt_a, nxt_b;
        logic [2:0]   rexp;
        int           k;

        n_checks    = 0;
        n_errors    = 0;
        overlap_cnt = 0;

        vecs[0] = '{96'h123456_ABCDEF_000000_FFFFFF, 96'h123456_ABCDEF_000000_FFFFFF, 3'b010, "equal"};
        vecs[1] = '{96'h1, 96'h0, 3'b100, "lsb_gt"};
        vecs[2] = '{96'h0, 96'h1, 3'b001, "lsb_lt"};
        vecs[3] = '{{24'h000001, 72'h0}, {24'h000000, {72{1'b1}}}, 3'b100, "msb_gt"};
        vecs[4] = '{{24'h000000, {72{1'b1}}}, {24'h000001, 72'h0}, 3'b001, "msb_lt"};
        vecs[5] = '{{24'hFFFFFF, 72'h0}, {24'hFFFFFF, 72'h1}, 3'b001, "msb_eq_lsb_lt"};
        vecs[6] = '{{96{1'b1}}, {{95{1'b1}}, 1'b0}, 3'b100, "ones"};
        vecs[7] = '{96'h000000_000002_000000_FFFFFF, 96'h000000_000001_FFFFFF_000000, 3'b100, "mid_word"};

        // Reset with in_valid high: nothing is accepted.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 96'h5;
        b         = 96'h3;
        repeat (2) @(negedge clk);
        check("reset ready/valid", W'({in_ready, out_valid}), W'(2'b10));
        check("reset flags", W'({great, equal, less}), W'(3'b000));
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("no accept in reset", W'({in_ready, out_valid}), W'(2'b10));

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].name);
            wait_result(vecs[i].exp, vecs[i].name);
            release_result(1, vecs[i].exp, vecs[i].name);
        end

        // Backpressure: result held while new operands wait with in_valid high.
        accept(96'h7, 96'h9, "bp first");
        wait_result(3'b001, "bp first");
        nxt_a    = {24'hABCDEF, 72'h0};
        nxt_b    = {24'hABCDEE, {72{1'b1}}};
        a        = nxt_a;
        b        = nxt_b;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp hold", W'({out_valid, in_ready, great, equal, less}), W'(5'b10001));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp to idle", W'({out_valid, in_ready}), W'(2'b01));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp accepted", W'(in_ready), W'(0));
        wait_result(3'b100, "bp second");
        release_result(0, 3'b100, "bp second");

        // Reset in the second BUSY cycle aborts the operation.
        accept(96'h1, 96'h2, "abort");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort reset state", W'({in_ready, out_valid, great, equal, less}), W'(5'b10000));
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        check("abort no out_valid", W'(k), W'(0));

        // Random operands with random output stalls.
        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = {$urandom, $urandom, $urandom};
                1: rb = ra;
                2: begin
                    rb = ra;
                    k  = $urandom_range(0, WORDS - 1);
                    rb[24*k +: 24] = 24'($urandom);
                end
                default: begin
                    rb = ra;
                    rb[$urandom_range(0, W - 1)] ^= 1'b1;
                end
            endcase
            rexp = ref_cmp(ra, rb);
            accept(ra, rb, "rand");
            wait_result(rexp, "rand");
            release_result($urandom_range(0, 3), rexp, "rand");
        end

        check("ready/valid overlap", W'(overlap_cnt), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multiword_comparator_seq.md
# multiword_comparator_seq

Sequential unsigned magnitude comparator for operands wider than 24 bits, built around a single Comparator_24 instance. Operands are split into 24-bit words and compared one word per clock, LSB word first. The registered great/equal/less flags are fed back into the instance's cascade inputs on each step. This is the stage directly upstream of Comparator_24: it generates that block's word operands and cascade inputs and consumes its outputs, behind a valid/ready handshake.

## Interface
- WORDS, 4, number of 24-bit words per operand; operand width is 24*WORDS; legal range 1..64.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  24*WORDS  operand A, unsigned; sampled on accept only.
- b  input  24*WORDS  operand B, unsigned; sampled on accept only.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes the result.
- great  output  1  A > B; registered.
- equal  output  1  A == B; registered.
- less  output  1  A < B; registered.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a and b into internal registers, clear the word index to 0, set running flags to great=0, equal=1, less=0, go to BUSY.
- BUSY:
  - The Comparator_24 instance sees word idx of each latched operand, i.e. bits [24*idx+23 : 24*idx].
  - Its cascade inputs (greatin/equalin/lessin) are the running flags.
  - Its outputs are written back into the running flags every cycle.
  - idx increments each cycle.
  - When idx==WORDS-1 is processed, the running result is copied into great/equal/less and the FSM goes to DONE.
- Cascade semantics: a word that differs overrides the cascade inputs. Equal words pass the cascade inputs through. The most significant differing word therefore decides the result.
- DONE:
  - out_valid=1; great/equal/less are held stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored in DONE because in_ready=0.
- Exactly one of great/equal/less is 1 after the first completed operation.
- Output flags change only on the DONE-entry edge. They hold their last value in IDLE and BUSY, and are meaningful only while out_valid=1.
- in_valid is ignored while in BUSY or DONE.
- Input operands may change freely after the accept edge, because the latched copy is used.
- Arithmetic:
  - Unsigned only.
  - No early termination: all WORDS words are always processed.
  - The index counter is ceil(log2(WORDS))+1 bits wide and never wraps inside an operation.

## Timing
- Reset state, visible after the first rising edge with rst_n=0:
  - FSM=IDLE, in_ready=1, out_valid=0.
  - great=0, equal=0, less=0; running flags cleared; idx=0.
- Accept at edge E0: in_valid & in_ready.
- Word k is processed in the cycle between edges E(k) and E(k+1).
- DONE is entered at edge E(WORDS); out_valid is first high in the cycle after E(WORDS). Latency is WORDS cycles from accept to out_valid.
- Leaving DONE: handshake at edge Ed (out_valid & out_ready) returns the FSM to IDLE, and out_valid is low in the next cycle.
- The earliest next accept is the edge after Ed. Peak throughput is one result per WORDS+2 cycles.
- WORDS=1: BUSY lasts one cycle and latency is 1.
- Reset mid-operation (rst_n=0 in BUSY or DONE):
  - The next edge forces the reset state; the in-flight result is discarded.
  - No out_valid pulse is produced for the aborted operation.
- in_ready and out_valid are decoded directly from the FSM state register. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, great=equal=less=0, and no accept happens.
- Equality, WORDS=4: a=b=96'h123456_ABCDEF_000000_FFFFFF -> out_valid exactly 4 cycles after accept, with equal=1, great=0, less=0.
- LSB decides: a=96'h1, b=96'h0 -> great=1. Swapping the operands -> less=1.
- MSB overrides LSB:
  - a={24'h000001,72'h0}, b={24'h000000,{72{1'b1}}} -> great=1.
  - Swapped -> less=1.
  - a={24'hFFFFFF,72'h0}, b={24'hFFFFFF,72'h1} -> less=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and new operands applied -> out_valid and the flags stay held, in_ready=0, and no new operation starts. Raising out_ready -> IDLE in the next cycle, then the new operands are accepted and compared correctly.
- Reset abort, then random: assert rst_n=0 in the 2nd BUSY cycle -> reset state with no out_valid. Then run 1000 random a/b pairs with random out_ready stalls -> every result matches the reference a>b / a==b / a<b, and in_ready is never high together with out_valid.
